// File: rtl/acc_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_writeback_pkg
// Brief    : Shared constants, width helper and FSM encoding for the
//            accumulator write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
package acc_writeback_pkg;

  // Default geometry of the systolic array datapath.
  localparam int WB_DATA_NUM  = 16;
  localparam int WB_DATA_SIZE = 8;
  localparam int WB_ACC_DEPTH = 64;
  localparam int WB_UB_DEPTH  = 256;

  // Number of bits needed to represent value (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_skid_fifo
// Brief    : Two-entry FIFO absorbing the accumulator read latency and
//            unified-buffer backpressure. Each entry holds {address, row}.
// Revision : 1.0 - initial release
// ============================================================================
module wb_skid_fifo #(
  parameter int WIDTH = 136
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/acc_writeback.sv
`default_nettype none
// ============================================================================
// Module   : acc_writeback
// Brief    : Streams a range of accumulator rows through optional per-lane
//            ReLU into the unified buffer under valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module acc_writeback
  import acc_writeback_pkg::*;
#(
  parameter int DATA_NUM  = WB_DATA_NUM,
  parameter int DATA_SIZE = WB_DATA_SIZE,
  parameter int ACC_DEPTH = WB_ACC_DEPTH,
  parameter int UB_DEPTH  = WB_UB_DEPTH,
  localparam int ROW_WIDTH = DATA_NUM * DATA_SIZE,
  localparam int AW        = clogb2(ACC_DEPTH - 1),
  localparam int UW        = clogb2(UB_DEPTH - 1),
  localparam int LW        = clogb2(ACC_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [AW-1:0]        i_src_addr,
  input  logic [UW-1:0]        i_dst_addr,
  input  logic [LW-1:0]        i_len,
  input  logic                 i_relu_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_acc_enb,
  output logic [AW-1:0]        o_acc_addrb,
  input  logic [ROW_WIDTH-1:0] i_acc_doutb,
  output logic                 o_ub_valid,
  input  logic                 i_ub_ready,
  output logic [UW-1:0]        o_ub_addr,
  output logic [ROW_WIDTH-1:0] o_ub_din
);

  wb_state_t r_state;
  wb_state_t w_state_nxt;

  logic [AW-1:0]        r_src;
  logic [UW-1:0]        r_dst;
  logic [LW-1:0]        r_len;
  logic                 r_relu;
  logic [LW-1:0]        r_issue_cnt;
  logic [LW-1:0]        r_wr_cnt;
  logic                 r_inflight;

  logic                 w_issue;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [1:0]           w_count;
  logic [2:0]           w_credit;
  logic [UW-1:0]        w_push_addr;
  logic [ROW_WIDTH-1:0] w_relu_row;
  logic [UW+ROW_WIDTH-1:0] w_head;

  // A row counts against the two skid slots from issue until it is popped;
  // a slot freed by this cycle's pop can be reused immediately.
  assign w_credit = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_pop    = (r_state == ST_RUN) && !w_empty && i_ub_ready;
  assign w_issue  = (r_state == ST_RUN) && (r_issue_cnt < r_len) && !w_full &&
                    (w_credit < (3'd2 + {2'b00, w_pop}));

  assign o_acc_enb   = w_issue;
  assign o_acc_addrb = r_src + r_issue_cnt[AW-1:0];

  // The row captured now was issued last cycle, so its index is issue_cnt-1.
  assign w_push_addr = r_dst + UW'(r_issue_cnt) - UW'(1);

  // Per-lane ReLU on the raw accumulator row before it is stored.
  for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_relu
    assign w_relu_row[gi*DATA_SIZE +: DATA_SIZE] =
      (r_relu && i_acc_doutb[gi*DATA_SIZE + DATA_SIZE - 1]) ?
        '0 : i_acc_doutb[gi*DATA_SIZE +: DATA_SIZE];
  end

  wb_skid_fifo #(
    .WIDTH (UW + ROW_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   ({w_push_addr, w_relu_row}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_ub_valid = !w_empty;
  assign o_ub_addr  = w_head[UW+ROW_WIDTH-1:ROW_WIDTH];
  assign o_ub_din   = w_head[ROW_WIDTH-1:0];

  // State register, command latch and issue/write counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_relu      <= 1'b0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if ((r_state == ST_IDLE) && i_start) begin
        r_src       <= i_src_addr;
        r_dst       <= i_dst_addr;
        r_len       <= i_len;
        r_relu      <= i_relu_en;
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + LW'(1);
        if (w_pop)   r_wr_cnt    <= r_wr_cnt + LW'(1);
      end
    end
  end

  // Next-state decode plus busy/done status.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = (i_len == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (w_pop && (r_wr_cnt == (r_len - LW'(1)))) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
